// File: rtl/fifo_serial_reader_pkg.sv
// Shared definitions for the FIFO serial reader: FSM state encoding and
// frame timing helpers.
package fifo_serial_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // Counter width for a count of 'count' states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count > 32'd1) ? $clog2(count) : 32'd1;
  endfunction

  // Cycles from the IDLE pop cycle through the last stop-bit cycle.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned bit_cycles);
    return 32'd2 + (data_width + 32'd2) * bit_cycles;
  endfunction

endpackage

// File: rtl/fifo_serial_reader_bit_tick_counter.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each
// serial bit so the reader knows when to advance.
module bit_tick_counter
  import fifo_serial_reader_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic CLEAR,
  output logic TICK
);

  localparam int CW = int'(cnt_width(BIT_CYCLES));
  localparam logic [CW-1:0] LAST_COUNT = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Bit timer: held at zero while cleared, wraps after the last bit cycle
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_r <= {CW{1'b0}};
    end else if (CLEAR || TICK) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1'b1);
    end
  end

  assign TICK = (count_r == LAST_COUNT);

endmodule

// File: rtl/fifo_serial_reader.sv
// Drains the FIFO one word at a time and sends each word as a framed serial
// character: start bit, data LSB first, stop bit.
module fifo_serial_reader
  import fifo_serial_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_EN,
  output logic                  TX_LINE,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int IW = int'(cnt_width(DATA_WIDTH));
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  state_t                state_r;
  state_t                state_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [IW-1:0]         bit_idx_r;
  logic                  tick_s;
  logic                  clear_s;

  // The bit timer only runs in the timed states, so START always sees a full period
  assign clear_s = (state_r == ST_IDLE) || (state_r == ST_FETCH);

  bit_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_tick_counter (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .CLEAR(clear_s),
    .TICK (tick_s)
  );

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register and bit index; the popped word lands at the end of FETCH
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_idx_r <= {IW{1'b0}};
    end else if (state_r == ST_FETCH) begin
      shift_r   <= FIFO_RD_DATA;
      bit_idx_r <= {IW{1'b0}};
    end else if ((state_r == ST_DATA) && tick_s) begin
      shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      bit_idx_r <= (bit_idx_r == LAST_BIT) ? {IW{1'b0}} : (bit_idx_r + IW'(1'b1));
    end else begin
      shift_r   <= shift_r;
      bit_idx_r <= bit_idx_r;
    end
  end

  // Next-state and output decode; only FIFO_RD_EN looks at inputs
  always_comb begin
    state_s    = state_r;
    FIFO_RD_EN = 1'b0;
    TX_LINE    = 1'b1;
    BUSY       = 1'b1;
    FRAME_DONE = 1'b0;
    case (state_r)
      ST_IDLE: begin
        BUSY       = 1'b0;
        FIFO_RD_EN = ENABLE && !FIFO_EMPTY && !RESET;
        if (FIFO_RD_EN) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_START;
      end
      ST_START: begin
        TX_LINE = 1'b0;
        if (tick_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        TX_LINE = shift_r[0];
        if (tick_s && (bit_idx_r == LAST_BIT)) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        FRAME_DONE = tick_s;
        if (tick_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        BUSY    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Directed bench for fifo_serial_reader: a default 4x4 instance and an 8-bit,
// one-clock-per-bit instance, each fed by a small FIFO model.
module tb_fifo_serial_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic       empty_a, rd_en_a, tx_a, busy_a, done_a;
  logic [3:0] rd_data_a;
  logic       empty_b, rd_en_b, tx_b, busy_b, done_b;
  logic [7:0] rd_data_b;

  fifo_serial_reader #(.DATA_WIDTH(4), .BIT_CYCLES(4)) dut_a (
    .CLOCK(clk), .RESET(reset), .ENABLE(enable), .FIFO_EMPTY(empty_a),
    .FIFO_RD_DATA(rd_data_a), .FIFO_RD_EN(rd_en_a), .TX_LINE(tx_a),
    .BUSY(busy_a), .FRAME_DONE(done_a)
  );

  fifo_serial_reader #(.DATA_WIDTH(8), .BIT_CYCLES(1)) dut_b (
    .CLOCK(clk), .RESET(reset), .ENABLE(enable), .FIFO_EMPTY(empty_b),
    .FIFO_RD_DATA(rd_data_b), .FIFO_RD_EN(rd_en_b), .TX_LINE(tx_b),
    .BUSY(busy_b), .FRAME_DONE(done_b)
  );

  logic [3:0] q_a[$];
  logic [7:0] q_b[$];
  bit         pend_a, pend_b;
  int         cyc, pops_a, pops_b, last_pop_a, last_pop_b;
  int         pop_hist_a[$];
  logic       tx_log_a[0:1999], busy_log_a[0:1999], done_log_a[0:1999], rd_log_a[0:1999];
  logic       tx_log_b[0:1999], busy_log_b[0:1999], done_log_b[0:1999];
  int         n_vec, n_miss;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: present FIFO state, sample outputs mid-cycle, advance past the edge.
  task automatic run_cycle();
    if (pend_a) begin
      rd_data_a = (q_a.size() > 0) ? q_a.pop_front() : 4'h0;
      pend_a = 1'b0;
    end
    if (pend_b) begin
      rd_data_b = (q_b.size() > 0) ? q_b.pop_front() : 8'h00;
      pend_b = 1'b0;
    end
    empty_a = (q_a.size() == 0);
    empty_b = (q_b.size() == 0);
    #1;
    tx_log_a[cyc] = tx_a; busy_log_a[cyc] = busy_a; done_log_a[cyc] = done_a; rd_log_a[cyc] = rd_en_a;
    tx_log_b[cyc] = tx_b; busy_log_b[cyc] = busy_b; done_log_b[cyc] = done_b;
    if (rd_en_a === 1'b1) begin
      pend_a = 1'b1; pops_a++; last_pop_a = cyc; pop_hist_a.push_back(cyc);
    end
    if (rd_en_b === 1'b1) begin
      pend_b = 1'b1; pops_b++; last_pop_b = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  function automatic logic tx_at(input bit use_b, input int c);
    return use_b ? tx_log_b[c] : tx_log_a[c];
  endfunction
  function automatic logic busy_at(input bit use_b, input int c);
    return use_b ? busy_log_b[c] : busy_log_a[c];
  endfunction
  function automatic logic done_at(input bit use_b, input int c);
    return use_b ? done_log_b[c] : done_log_a[c];
  endfunction

  // seq[i] is the i-th line bit after FETCH (start, data LSB first, stop).
  task automatic check_frame(input string tag, input bit use_b, input int p,
                             input logic [15:0] seq, input int nb, input int bc);
    int last;
    last = p + 2 + nb * bc - 1;
    check_eq({tag, "_pop_tx"},    tx_at(use_b, p), 32'd1);
    check_eq({tag, "_fetch_tx"},  tx_at(use_b, p + 1), 32'd1);
    check_eq({tag, "_pop_busy"},  busy_at(use_b, p), 32'd0);
    check_eq({tag, "_fetch_busy"}, busy_at(use_b, p + 1), 32'd1);
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < bc; j++)
        check_eq($sformatf("%s_bit%0d_%0d", tag, i, j), tx_at(use_b, p + 2 + i * bc + j), 32'(seq[i]));
    check_eq({tag, "_done_early"}, done_at(use_b, last - 1), 32'd0);
    check_eq({tag, "_done"},       done_at(use_b, last), 32'd1);
    check_eq({tag, "_busy_last"},  busy_at(use_b, last), 32'd1);
    check_eq({tag, "_busy_after"}, busy_at(use_b, last + 1), 32'd0);
  endtask

  initial begin
    int base, h, p;
    n_vec = 0; n_miss = 0; cyc = 0;
    pops_a = 0; pops_b = 0; last_pop_a = 0; last_pop_b = 0;
    pend_a = 1'b0; pend_b = 1'b0;
    rd_data_a = 4'h0; rd_data_b = 8'h00;
    empty_a = 1'b1; empty_b = 1'b1;
    reset = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1;

    // Reset then idle with an empty FIFO
    run(2);
    check_eq("rst_tx",   32'(tx_log_a[1]), 32'd1);
    check_eq("rst_busy", 32'(busy_log_a[1]), 32'd0);
    check_eq("rst_done", 32'(done_log_a[1]), 32'd0);
    check_eq("rst_rden", 32'(rd_log_a[1]), 32'd0);
    check_eq("rst_tx_b", 32'(tx_log_b[1]), 32'd1);
    reset = 1'b0;
    run(50);
    for (int c = 2; c < 52; c++) begin
      check_eq("idle_tx",   32'(tx_log_a[c]), 32'd1);
      check_eq("idle_busy", 32'(busy_log_a[c]), 32'd0);
      check_eq("idle_rden", 32'(rd_log_a[c]), 32'd0);
    end

    // Single word 4'hA: line 0,0,1,0,1,1
    base = pops_a;
    q_a.push_back(4'hA);
    run(30);
    check_eq("single_pops", 32'(pops_a - base), 32'd1);
    check_frame("single_A", 1'b0, last_pop_a, 16'h0034, 6, 4);

    // Back-to-back 1, 6, F
    base = pops_a;
    h = pop_hist_a.size();
    q_a.push_back(4'h1); q_a.push_back(4'h6); q_a.push_back(4'hF);
    run(90);
    check_eq("b2b_pops", 32'(pops_a - base), 32'd3);
    if (pop_hist_a.size() >= h + 3) begin
      check_eq("b2b_gap1", 32'(pop_hist_a[h + 1] - pop_hist_a[h]), 32'd26);
      check_eq("b2b_gap2", 32'(pop_hist_a[h + 2] - pop_hist_a[h + 1]), 32'd26);
      check_frame("b2b_1", 1'b0, pop_hist_a[h],     16'h0022, 6, 4);
      check_frame("b2b_6", 1'b0, pop_hist_a[h + 1], 16'h002C, 6, 4);
      check_frame("b2b_F", 1'b0, pop_hist_a[h + 2], 16'h003E, 6, 4);
    end else begin
      check_eq("b2b_hist", 32'(pop_hist_a.size() - h), 32'd3);
    end

    // ENABLE dropped during DATA: frame 4'h5 completes, 4'h9 waits
    base = pops_a;
    q_a.push_back(4'h5); q_a.push_back(4'h9);
    run(1);
    p = last_pop_a;
    run(8);
    enable = 1'b0;
    run(60);
    check_eq("en_pops_held", 32'(pops_a - base), 32'd1);
    check_eq("en_fifo_left", 32'(q_a.size()), 32'd1);
    check_frame("en_5", 1'b0, p, 16'h002A, 6, 4);
    enable = 1'b1;
    run(30);
    check_eq("en_pops_resume", 32'(pops_a - base), 32'd2);
    check_frame("en_9", 1'b0, last_pop_a, 16'h0032, 6, 4);

    // RESET for one cycle during DATA: 4'h3 abandoned, 4'hC sent cleanly
    base = pops_a;
    q_a.push_back(4'h3); q_a.push_back(4'hC);
    run(1);
    p = last_pop_a;
    run(8);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(30);
    check_eq("rmid_tx",   32'(tx_log_a[p + 10]), 32'd1);
    check_eq("rmid_busy", 32'(busy_log_a[p + 10]), 32'd0);
    check_eq("rmid_pops", 32'(pops_a - base), 32'd2);
    check_eq("rmid_repop", 32'(last_pop_a - p), 32'd10);
    check_frame("rmid_C", 1'b0, last_pop_a, 16'h0038, 6, 4);

    // 8-bit, one clock per bit: 8'hC3 gives line 0,1,1,0,0,0,0,1,1,1
    base = pops_b;
    q_b.push_back(8'hC3);
    run(15);
    check_eq("b_pops", 32'(pops_b - base), 32'd1);
    check_frame("b_C3", 1'b1, last_pop_b, 16'h0386, 10, 1);

    check_eq("total_pops_a", 32'(pops_a), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
